// File: rtl/mazesolver_soc_pio_pkg.sv
// mazesolver_soc_pio_pkg
// Shared definitions for the SoC parallel I/O blocks: Avalon word
// addresses of the output PIO register map and STATUS bit positions.
package mazesolver_soc_pio_pkg;

  localparam logic [2:0] ADDR_DATA         = 3'd0;
  localparam logic [2:0] ADDR_BLINK_MASK   = 3'd1;
  localparam logic [2:0] ADDR_BLINK_PERIOD = 3'd2;
  localparam logic [2:0] ADDR_STATUS       = 3'd3;
  localparam logic [2:0] ADDR_OUTSET       = 3'd4;
  localparam logic [2:0] ADDR_OUTCLEAR     = 3'd5;

  localparam int STATUS_PHASE_BIT  = 0;
  localparam int STATUS_ACTIVE_BIT = 1;

endpackage

// File: rtl/mazesolver_soc_led_out_if.sv
// mazesolver_soc_led_out_if
// Avalon-MM slave bus bundle for the LED output PIO.
//   address    word address (3 bits)
//   chipselect slave select
//   write_n    active-low write strobe, qualified by chipselect
//   writedata  32-bit write data
//   readdata   32-bit registered read data (slave -> master)
// Modports: master (interconnect side), slave (PIO side).
interface mazesolver_soc_led_out_if;

  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address,
    output chipselect,
    output write_n,
    output writedata,
    input  readdata
  );

  modport slave (
    input  address,
    input  chipselect,
    input  write_n,
    input  writedata,
    output readdata
  );

endinterface

// File: rtl/mazesolver_soc_blink_timer.sv
// mazesolver_soc_blink_timer
// Half-period counter that toggles a phase bit every 'period' clk cycles.
//   clk      system clock
//   reset_n  synchronous active-low reset
//   period   half-period in cycles; 0 holds counter and phase at 0
//   restart  clears counter and phase this edge (takes priority over a toggle)
//   phase    current blink phase
module mazesolver_soc_blink_timer (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] period,
  input  logic        restart,
  output logic        phase
);

  logic [31:0] count_reg, count_next;
  logic        phase_reg, phase_next;

  always_comb begin
    count_next = count_reg;
    phase_next = phase_reg;
    if (restart || (period == 32'd0)) begin
      count_next = 32'd0;
      phase_next = 1'b0;
    end else if (count_reg == period - 32'd1) begin
      // Counter never exceeds period-1, so it cannot wrap at 32'hFFFFFFFF.
      count_next = 32'd0;
      phase_next = ~phase_reg;
    end else begin
      count_next = count_reg + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      count_reg <= 32'd0;
      phase_reg <= 1'b0;
    end else begin
      count_reg <= count_next;
      phase_reg <= phase_next;
    end
  end

  assign phase = phase_reg;

endmodule

// File: rtl/mazesolver_soc_led_out.sv
// mazesolver_soc_led_out
// Avalon-MM slave output PIO driving board LEDs / indicator lines.
// Holds DATA with atomic set/clear aliases and a masked hardware blink.
//   clk      system clock
//   reset_n  synchronous active-low reset
//   bus      Avalon-MM slave (address, chipselect, write_n, writedata, readdata)
//   out_port WIDTH-bit output = DATA ^ (BLINK_MASK & phase), purely from flops
module mazesolver_soc_led_out
  import mazesolver_soc_pio_pkg::*;
#(
  parameter int               WIDTH       = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic                     clk,
  input  logic                     reset_n,
  mazesolver_soc_led_out_if.slave  bus,
  output logic [WIDTH-1:0]         out_port
);

  logic [WIDTH-1:0] data_reg, data_next;
  logic [WIDTH-1:0] mask_reg, mask_next;
  logic [31:0]      period_reg, period_next;
  logic [31:0]      readdata_reg, readdata_next;
  logic             restart;
  logic             phase;
  logic             wr_en;
  logic [WIDTH-1:0] wdata;
  logic [31:0]      wdata_unused;

  assign wr_en        = bus.chipselect && !bus.write_n;
  assign wdata        = bus.writedata[WIDTH-1:0];
  // Bits above WIDTH carry no meaning for this block.
  assign wdata_unused = bus.writedata;

  always_comb begin
    data_next   = data_reg;
    mask_next   = mask_reg;
    period_next = period_reg;
    restart     = 1'b0;
    if (wr_en) begin
      case (bus.address)
        ADDR_DATA:         data_next = wdata;
        ADDR_BLINK_MASK:   mask_next = wdata;
        ADDR_BLINK_PERIOD: begin
          period_next = bus.writedata;
          restart     = 1'b1;
        end
        // Set/clear act on stored DATA, never on the blinked output.
        ADDR_OUTSET:       data_next = data_reg | wdata;
        ADDR_OUTCLEAR:     data_next = data_reg & ~wdata;
        default:           ;
      endcase
    end
  end

  // Read mux samples current (pre-write) register values.
  always_comb begin
    readdata_next = 32'd0;
    case (bus.address)
      ADDR_DATA:         readdata_next = 32'(data_reg);
      ADDR_BLINK_MASK:   readdata_next = 32'(mask_reg);
      ADDR_BLINK_PERIOD: readdata_next = period_reg;
      ADDR_STATUS: begin
        readdata_next[STATUS_PHASE_BIT]  = phase;
        readdata_next[STATUS_ACTIVE_BIT] = (period_reg != 32'd0);
      end
      default:           readdata_next = 32'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      data_reg     <= RESET_VALUE;
      mask_reg     <= '0;
      period_reg   <= 32'd0;
      readdata_reg <= 32'd0;
    end else begin
      data_reg     <= data_next;
      mask_reg     <= mask_next;
      period_reg   <= period_next;
      readdata_reg <= readdata_next;
    end
  end

  mazesolver_soc_blink_timer u_blink_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .period  (period_reg),
    .restart (restart),
    .phase   (phase)
  );

  assign bus.readdata = readdata_reg;

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_out
    assign out_port[gi] = data_reg[gi] ^ (mask_reg[gi] & phase);
  end

endmodule

// File: tb/tb_mazesolver_soc_led_out.sv
// tb_mazesolver_soc_led_out
// Directed self-checking bench for the LED output PIO (WIDTH=8,
// RESET_VALUE=8'hA5). Inputs change on the falling edge, outputs are
// sampled 1 time unit after the rising edge.
module tb_mazesolver_soc_led_out;

  logic       clk;
  logic       reset_n;
  logic [7:0] out_port;
  int         checks;
  int         errors;
  logic [31:0] rd;
  logic [31:0] exp_reset [8];

  mazesolver_soc_led_out_if bus_if ();

  mazesolver_soc_led_out #(
    .WIDTH       (8),
    .RESET_VALUE (8'hA5)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .bus      (bus_if),
    .out_port (out_port)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed,
                       input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic bus_write(input logic [2:0] addr, input logic [31:0] data);
    @(negedge clk);
    bus_if.address    = addr;
    bus_if.chipselect = 1'b1;
    bus_if.write_n    = 1'b0;
    bus_if.writedata  = data;
    @(posedge clk);
    #1;
    bus_if.chipselect = 1'b0;
    bus_if.write_n    = 1'b1;
    $display("WR addr=%0d data=%h out_port=%h", addr, data, out_port);
  endtask

  task automatic bus_read(input logic [2:0] addr, output logic [31:0] data);
    @(negedge clk);
    bus_if.address    = addr;
    bus_if.chipselect = 1'b1;
    bus_if.write_n    = 1'b1;
    @(posedge clk);
    #1;
    data              = bus_if.readdata;
    bus_if.chipselect = 1'b0;
    $display("RD addr=%0d data=%h out_port=%h", addr, data, out_port);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    $display("CY out_port=%h", out_port);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    exp_reset = '{32'hA5, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
    reset_n           = 1'b0;
    bus_if.address    = 3'd0;
    bus_if.chipselect = 1'b0;
    bus_if.write_n    = 1'b1;
    bus_if.writedata  = 32'd0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("reset_out", 32'(out_port), 32'hA5);
    check("reset_readdata", bus_if.readdata, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      bus_read(3'(i), rd);
      check($sformatf("reset_rd%0d", i), rd, exp_reset[i]);
    end

    // DATA write, upper bits ignored; same-cycle read returns pre-write value
    bus_write(3'd0, 32'hFFFF_FF3C);
    check("data_wr_out", 32'(out_port), 32'h3C);
    check("rd_during_wr", bus_if.readdata, 32'hA5);
    bus_read(3'd0, rd);
    check("data_rd", rd, 32'h3C);

    // OUTSET / OUTCLEAR
    bus_write(3'd0, 32'h0F);
    bus_write(3'd4, 32'h30);
    check("outset", 32'(out_port), 32'h3F);
    bus_write(3'd5, 32'h03);
    check("outclear", 32'(out_port), 32'h3C);
    bus_read(3'd4, rd);
    check("outset_rd", rd, 32'h0);
    bus_read(3'd5, rd);
    check("outclear_rd", rd, 32'h0);

    // Blink, period 3: phase toggles on the 3rd, 6th, ... edge after the write
    bus_write(3'd0, 32'h00);
    bus_write(3'd1, 32'h81);
    bus_write(3'd2, 32'd3);
    check("blink_e0", 32'(out_port), 32'h00);
    for (int k = 1; k <= 6; k++) begin
      tick();
      check($sformatf("blink_e%0d", k), 32'(out_port),
            (k >= 3 && k < 6) ? 32'h81 : 32'h00);
    end
    // Counter=0, phase=0 now; STATUS sampled before each of the next edges
    bus_read(3'd3, rd);
    check("status_a", rd, 32'h2);
    bus_read(3'd3, rd);
    check("status_b", rd, 32'h2);
    bus_read(3'd3, rd);
    check("status_c", rd, 32'h2);
    bus_read(3'd3, rd);
    check("status_d", rd, 32'h3);
    check("phase1_out", 32'(out_port), 32'h81);
    bus_read(3'd2, rd);
    check("period_rd", rd, 32'd3);

    // Disable mid-blink with phase=1
    bus_write(3'd2, 32'd0);
    check("disable_out", 32'(out_port), 32'h00);
    bus_read(3'd3, rd);
    check("disable_status", rd, 32'h0);

    // Rewrite period at terminal count: restart wins, no toggle
    bus_write(3'd2, 32'd3);
    tick();
    check("term_e1", 32'(out_port), 32'h00);
    tick();
    check("term_e2", 32'(out_port), 32'h00);
    bus_write(3'd2, 32'd3);
    check("term_rewrite", 32'(out_port), 32'h00);
    tick();
    check("term_r1", 32'(out_port), 32'h00);
    tick();
    check("term_r2", 32'(out_port), 32'h00);
    tick();
    check("term_r3", 32'(out_port), 32'h81);

    // Mask write does not disturb counter or phase
    bus_write(3'd1, 32'h0F);
    check("mask_e1", 32'(out_port), 32'h0F);
    tick();
    check("mask_e2", 32'(out_port), 32'h0F);
    tick();
    check("mask_e3", 32'(out_port), 32'h00);

    // Reset mid-blink with DATA modified
    bus_write(3'd0, 32'h55);
    check("pre_reset_out", 32'(out_port), 32'h55);
    @(negedge clk);
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    check("midreset_out", 32'(out_port), 32'hA5);
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      bus_read(3'(i), rd);
      check($sformatf("postreset_rd%0d", i), rd, exp_reset[i]);
    end
    tick();
    check("postreset_out", 32'(out_port), 32'hA5);

    // Reserved address write is ignored
    bus_write(3'd7, 32'hFFFF_FFFF);
    bus_write(3'd6, 32'hFFFF_FFFF);
    check("reserved_out", 32'(out_port), 32'hA5);
    for (int i = 0; i < 4; i++) begin
      bus_read(3'(i), rd);
      check($sformatf("reserved_rd%0d", i), rd, exp_reset[i]);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mazesolver_soc_led_out.md
Name: mazesolver_soc_led_out

Overview:
- Avalon-MM slave output PIO. It is the write-side counterpart to the key input PIOs; it drives board LEDs and indicator lines from Nios software.
- Holds an output data register with atomic bit set/clear aliases.
- An optional hardware blink engine toggles a masked subset of the outputs at a programmable half-period, so software does not need to poll timers.
- Sits on the SoC's Avalon interconnect next to the key PIOs.

Parameters:
- WIDTH, 8, number of output bits (1..32).
- RESET_VALUE, 0, value loaded into DATA on reset.

Ports:
- clk  in  1  system clock
- reset_n  in  1  synchronous active-low reset
- address  in  3  Avalon word address
- chipselect  in  1  slave select
- write_n  in  1  active-low write strobe, qualified by chipselect
- writedata  in  32  write data
- readdata  out  32  registered read data
- out_port  out  WIDTH  driven outputs

Behaviour:
- Reset:
  - Single clock clk. Reset is synchronous and active-low on reset_n, sampled on the rising clk edge.
  - On reset: DATA=RESET_VALUE, BLINK_MASK=0, BLINK_PERIOD=0, counter=0, phase=0, readdata=0.
  - out_port therefore equals RESET_VALUE in the cycle after reset is sampled.
- Register map (word addresses):
  - 0 DATA: read/write, bits [WIDTH-1:0].
  - 1 BLINK_MASK: read/write, bits [WIDTH-1:0].
  - 2 BLINK_PERIOD: read/write, 32-bit half-period in clk cycles. 0 disables blinking.
  - 3 STATUS: read-only. bit0 = phase, bit1 = blink_active (BLINK_PERIOD != 0).
  - 4 OUTSET: write-only. DATA <= DATA | writedata[WIDTH-1:0]. Reads return 0.
  - 5 OUTCLEAR: write-only. DATA <= DATA & ~writedata[WIDTH-1:0]. Reads return 0.
  - 6, 7: reserved. Writes are ignored; reads return 0.
- Writes:
  - A write occurs when chipselect=1 and write_n=0 at a rising edge.
  - writedata bits above WIDTH are ignored.
  - The new register value is visible on out_port immediately after that edge.
- Reads:
  - readdata is registered every cycle from address. Read data is valid one cycle after address is presented (no wait states).
  - Unused upper bits read as 0.
  - A read in the same cycle as a write to the same address returns the pre-write value.
- Output:
  - out_port = DATA ^ (BLINK_MASK & {WIDTH{phase}}).
  - out_port is combinational from flops only. No combinational path from bus inputs.
- Blink engine (32-bit counter):
  - If BLINK_PERIOD==0: counter=0 and phase=0, held.
  - Otherwise the counter increments each cycle. When counter==BLINK_PERIOD-1, counter<=0 and phase toggles.
  - BLINK_PERIOD=1 therefore toggles phase every cycle.
- Boundary cases:
  - Any write to BLINK_PERIOD clears counter and phase in the same edge, even when the counter is at terminal count. The write wins and no toggle occurs.
  - Writing BLINK_MASK does not disturb counter or phase.
  - Counter reaches at most BLINK_PERIOD-1, so no wrap hazard exists at 32'hFFFFFFFF.
  - OUTSET/OUTCLEAR act on the stored DATA, not on the blinked out_port value.
  - Reset asserted mid-blink returns everything to reset values at the next edge.

Decomposition:
- Shared package mazesolver_soc_pio_pkg: register address constants ADDR_DATA=0, ADDR_BLINK_MASK=1, ADDR_BLINK_PERIOD=2, ADDR_STATUS=3, ADDR_OUTSET=4, ADDR_OUTCLEAR=5, plus STATUS bit indices.
- One natural sub-module: mazesolver_soc_blink_timer. It holds the counter and phase, with inputs period and restart and output phase.
- Register file and read mux stay in the top module.

Test Plan:
- Reset with RESET_VALUE=8'hA5 -> out_port=8'hA5; reads of addr 0..7 return 32'hA5, 0, 0, 0, 0, 0, 0, 0 with 1-cycle latency.
- Write DATA=32'hFFFF_FF3C -> out_port=8'h3C next cycle; read addr0 returns 32'h0000_003C.
- DATA=8'h0F, OUTSET 8'h30 -> 8'h3F; then OUTCLEAR 8'h03 -> 8'h3C; then read addr4 -> 0.
- DATA=8'h00, BLINK_MASK=8'h81, BLINK_PERIOD=3 -> out_port alternates 8'h00/8'h81 every 3 cycles; STATUS bit1=1 and bit0 tracks phase.
- Mid-blink with phase=1, write BLINK_PERIOD=0 -> out_port returns to DATA at the next edge; STATUS=0. Rewriting period 3 at terminal count -> counter restarts from 0 with no toggle.
- Assert reset_n=0 for one cycle during blinking with DATA modified -> all registers return to reset values; write to addr 7 -> no register changes.
